beat_sequencer: RTL and testbench
=================================

// Module: beat_sequencer
// PURPOSE
//  Consumer of the timing chain's divided beat flag (freqDivider cout). Each new beat
//  steps a pointer through a small writable note-pattern RAM and emits that step's lane
//  bitmap as a one-cycle note event for the note-spawn/display logic.
//  It also provides start/stop/pause control, optional looping and a done flag for game flow.
// PARAMETERS
//  LANES  4   lane-bitmap width, one bit per finger lane
//  DEPTH  16  pattern RAM entries; must equal 2**AW
//  AW     4   pattern address width
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  beat_in     in   1       divider terminal flag; may be held high several cycles
//  start       in   1       begin playback from step 0 (IDLE/DONE only)
//  stop        in   1       abort to IDLE from any state
//  pause       in   1       level; while high in RUN/PAUSE, beats are ignored
//  loop_en     in   1       1: wrap to step 0 after last step; 0: finish in DONE
//  len         in   AW+1    pattern length in steps, sampled on accepted start
//  wr_en       in   1       pattern RAM write strobe
//  wr_addr     in   AW      pattern RAM write address
//  wr_data     in   LANES   lane bitmap to write
//  note_valid  out  1       one-cycle pulse per consumed beat
//  note_lanes  out  LANES   bitmap of the emitted step; held until the next event
//  step        out  AW      index of the next step to be emitted
//  busy        out  1       high in RUN or PAUSE
//  paused      out  1       high in PAUSE
//  done        out  1       high in DONE
// BEHAVIOUR
//  Reset: state=IDLE, step=0, note_valid=0, note_lanes=0, busy=paused=done=0;
//   beat_q=1, so beat_in already high at reset release is not a beat. RAM is not reset.
//  Beat detect: beat_q registers beat_in each cycle; beat_rise = beat_in & ~beat_q.
//   One note per rising edge, however long beat_in stays high.
//  FSM: IDLE, RUN, PAUSE, DONE. Per-edge priority: rst > stop > start > pause > beat_rise.
//   IDLE/DONE + start: latch len_q = min(len, DEPTH), step=0, go RUN.
//     If len==0, ignore start and stay in the current state.
//   RUN + pause: go PAUSE. A beat_rise on the same edge is dropped.
//   PAUSE + !pause: go RUN. Beats seen while in PAUSE are lost, not queued.
//   RUN + beat_rise: note_lanes <= ram[step], note_valid <= 1 on that same edge,
//     so latency is 0 cycles after the edge that detects the rise (registered output).
//     If step == len_q-1: with loop_en, step <= 0 and stay in RUN;
//     otherwise step <= 0 and go DONE.
//     Else step <= step+1.
//   Any state + stop: go IDLE, step=0, note_valid=0. note_lanes is unchanged.
//   start in RUN/PAUSE: ignored. Restart requires stop first, or reaching DONE.
//  note_valid defaults to 0 on every edge that does not emit a note.
//  RAM: DEPTH x LANES. The write is accepted only when state is IDLE or DONE.
//   wr_en in RUN/PAUSE is ignored, so the pattern is frozen during play.
//   A write and a start on the same edge: the write lands first and is visible at step 0.
//  loop_en is sampled live at the last step, not latched at start.
//  Outputs busy, paused and done are decoded directly from the state register.
// TESTING
//  1. Write ram[0..3]=1,2,4,8; len=4, loop_en=0, start; give 4 beats, each held 3 cycles
//     -> exactly 4 note_valid pulses with lanes 1,2,4,8; then done=1, busy=0, step=0.
//  2. Same setup with loop_en=1 and 6 beats -> lanes 1,2,4,8,1,2;
//     step=2 at the end; done stays 0.
//  3. Hold beat_in=1 through rst release, then start -> no note until beat_in falls
//     and rises again.
//  4. Start, one beat, raise pause, 2 beats, drop pause, one beat -> 2 notes total,
//     lanes 1 then 2; paused=1 only during the pause window.
//  5. pause and beat_rise on the same edge -> no note, PAUSE entered.
//     stop together with start in IDLE -> stays IDLE.
//  6. wr_en to addr 1 with 4'hF during RUN -> ram[1] unchanged (emits 2).
//     start with len=0 -> stays IDLE. len=20 -> wraps after 16 steps.

Source files
------------

// File: rtl/beat_sequencer.sv
// beat_sequencer: walks a writable note-pattern RAM one step per
// rising beat flag and emits each step's lane bitmap as a note event.
module beat_sequencer #(
    parameter int LANES = 4,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat_in,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             loop_en,
    input  logic [AW:0]      len,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [LANES-1:0] wr_data,
    output logic             note_valid,
    output logic [LANES-1:0] note_lanes,
    output logic [AW-1:0]    step,
    output logic             busy,
    output logic             paused,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t           r_state;
    logic [LANES-1:0] r_ram [DEPTH];
    logic             r_beat_q;
    logic [AW:0]      r_len_q;
    logic [AW-1:0]    r_step;
    logic             r_note_valid;
    logic [LANES-1:0] r_note_lanes;

    logic             w_beat_rise;
    logic             w_stopped;
    logic             w_last;
    logic [AW:0]      w_len_clip;

    assign w_beat_rise = beat_in & ~r_beat_q;
    assign w_stopped   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_last      = ({1'b0, r_step} == (r_len_q - 1'b1));
    assign w_len_clip  = (len > DEPTH_W) ? DEPTH_W : len;

    // Pattern RAM: writable only while playback is stopped
    always_ff @(posedge clk) begin
        if (wr_en && w_stopped) begin
            r_ram[wr_addr] <= wr_data;
        end
    end

    // Playback FSM with beat edge detect and registered note outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_beat_q     <= 1'b1;
            r_len_q      <= '0;
            r_step       <= '0;
            r_note_valid <= 1'b0;
            r_note_lanes <= '0;
        end else begin
            r_beat_q     <= beat_in;
            r_note_valid <= 1'b0;
            if (stop) begin
                r_state <= S_IDLE;
                r_step  <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start && (len != '0)) begin
                            r_len_q <= w_len_clip;
                            r_step  <= '0;
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (pause) begin
                            r_state <= S_PAUSE;
                        end else if (w_beat_rise) begin
                            r_note_valid <= 1'b1;
                            r_note_lanes <= r_ram[r_step];
                            if (w_last) begin
                                r_step <= '0;
                                if (!loop_en) begin
                                    r_state <= S_DONE;
                                end
                            end else begin
                                r_step <= r_step + 1'b1;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (!pause) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign note_valid = r_note_valid;
    assign note_lanes = r_note_lanes;
    assign step       = r_step;
    assign busy       = (r_state == S_RUN) || (r_state == S_PAUSE);
    assign paused     = (r_state == S_PAUSE);
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: vector table, directed corner sequences and
// randomized traffic against a behavioural playback model.
module tb_beat_sequencer;

    logic       clk;
    logic       rst;
    logic       beat_in;
    logic       start;
    logic       stop;
    logic       pause;
    logic       loop_en;
    logic [4:0] len;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       note_valid;
    logic [3:0] note_lanes;
    logic [3:0] step;
    logic       busy;
    logic       paused;
    logic       done;

    beat_sequencer dut (
        .clk(clk), .rst(rst), .beat_in(beat_in),
        .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .len(len), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .note_valid(note_valid), .note_lanes(note_lanes),
        .step(step), .busy(busy), .paused(paused), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model: mode names, pattern array, play position
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    int m_mode;
    int m_pos;
    int m_len;
    int m_prev;
    int m_valid;
    int m_lanes;
    int m_ram [16];

    int q_notes [$];

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rise;
        if (rst) begin
            m_mode  = M_IDLE;
            m_pos   = 0;
            m_valid = 0;
            m_lanes = 0;
            m_prev  = 1;
            return;
        end
        rise   = beat_in && (m_prev == 0);
        m_prev = beat_in;
        m_valid = 0;
        if (wr_en && (m_mode == M_IDLE || m_mode == M_DONE))
            m_ram[wr_addr] = int'(wr_data);
        if (stop) begin
            m_mode = M_IDLE;
            m_pos  = 0;
        end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
            if (start && len != 0) begin
                m_len  = (int'(len) > 16) ? 16 : int'(len);
                m_pos  = 0;
                m_mode = M_RUN;
            end
        end else if (m_mode == M_RUN) begin
            if (pause) begin
                m_mode = M_PAUSE;
            end else if (rise) begin
                m_valid = 1;
                m_lanes = m_ram[m_pos];
                m_pos   = (m_pos + 1) % m_len;
                if (m_pos == 0 && !loop_en) m_mode = M_DONE;
            end
        end else if (!pause) begin
            m_mode = M_RUN;
        end
    endtask

    // one clock: update model, clock DUT, compare every output
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("note_valid", int'(note_valid), m_valid);
        chk("note_lanes", int'(note_lanes), m_lanes);
        chk("step", int'(step), m_pos);
        chk("busy", int'(busy),
            int'(m_mode == M_RUN || m_mode == M_PAUSE));
        chk("paused", int'(paused), int'(m_mode == M_PAUSE));
        chk("done", int'(done), int'(m_mode == M_DONE));
        if (note_valid) q_notes.push_back(int'(note_lanes));
    endtask

    task automatic clr();
        start = 0;
        stop  = 0;
        wr_en = 0;
    endtask

    typedef struct {
        bit       beat;
        bit       st;
        bit       sp;
        bit       pa;
        bit       lp;
        bit [4:0] ln;
        bit       we;
        bit [3:0] wa;
        bit [3:0] wd;
        bit       ev;
        bit [3:0] el;
        bit [3:0] es;
        bit       eb;
        bit       ep;
        bit       ed;
    } vec_t;

    vec_t tv [17];
    int   e2 [6];

    initial begin
        tv[0]  = '{0,0,0,0,0,0,1,0,1, 0,0,0,0,0,0};
        tv[1]  = '{0,0,0,0,0,0,1,1,2, 0,0,0,0,0,0};
        tv[2]  = '{0,0,0,0,0,0,1,2,4, 0,0,0,0,0,0};
        tv[3]  = '{0,0,0,0,0,0,1,3,8, 0,0,0,0,0,0};
        tv[4]  = '{0,1,0,0,0,4,0,0,0, 0,0,0,1,0,0};
        tv[5]  = '{1,0,0,0,0,4,0,0,0, 1,1,1,1,0,0};
        tv[6]  = '{1,0,0,0,0,4,0,0,0, 0,1,1,1,0,0};
        tv[7]  = '{1,0,0,0,0,4,0,0,0, 0,1,1,1,0,0};
        tv[8]  = '{0,0,0,0,0,4,0,0,0, 0,1,1,1,0,0};
        tv[9]  = '{1,0,0,0,0,4,0,0,0, 1,2,2,1,0,0};
        tv[10] = '{1,0,0,0,0,4,0,0,0, 0,2,2,1,0,0};
        tv[11] = '{0,0,0,0,0,4,0,0,0, 0,2,2,1,0,0};
        tv[12] = '{1,0,0,0,0,4,0,0,0, 1,4,3,1,0,0};
        tv[13] = '{1,0,0,0,0,4,0,0,0, 0,4,3,1,0,0};
        tv[14] = '{0,0,0,0,0,4,0,0,0, 0,4,3,1,0,0};
        tv[15] = '{1,0,0,0,0,4,0,0,0, 1,8,0,0,0,1};
        tv[16] = '{0,0,0,0,0,4,0,0,0, 0,8,0,0,0,1};
        e2 = '{1, 2, 4, 8, 1, 2};

        for (int i = 0; i < 16; i++) m_ram[i] = 0;
        m_len = 1;
        rst = 1; beat_in = 0; pause = 0; loop_en = 0;
        len = 0; wr_addr = 0; wr_data = 0;
        clr();
        tick();
        tick();
        rst = 0;

        // table: pattern load and a non-looping play to DONE
        for (int i = 0; i < 17; i++) begin
            beat_in = tv[i].beat; start = tv[i].st;
            stop = tv[i].sp; pause = tv[i].pa;
            loop_en = tv[i].lp; len = tv[i].ln;
            wr_en = tv[i].we; wr_addr = tv[i].wa;
            wr_data = tv[i].wd;
            tick();
            chk($sformatf("tv%0d_valid", i), int'(note_valid), int'(tv[i].ev));
            chk($sformatf("tv%0d_lanes", i), int'(note_lanes), int'(tv[i].el));
            chk($sformatf("tv%0d_step", i), int'(step), int'(tv[i].es));
            chk($sformatf("tv%0d_busy", i), int'(busy), int'(tv[i].eb));
            chk($sformatf("tv%0d_paused", i), int'(paused), int'(tv[i].ep));
            chk($sformatf("tv%0d_done", i), int'(done), int'(tv[i].ed));
        end
        clr();

        // looping play, restart from DONE
        loop_en = 1; len = 4; start = 1;
        tick();
        clr();
        q_notes.delete();
        for (int i = 0; i < 6; i++) begin
            beat_in = 1; tick();
            beat_in = 0; tick();
        end
        chk("loop_count", q_notes.size(), 6);
        for (int i = 0; i < 6 && i < q_notes.size(); i++)
            chk($sformatf("loop_note%0d", i), q_notes[i], e2[i]);
        chk("loop_step", int'(step), 2);
        chk("loop_done", int'(done), 0);

        // beat held high through reset release
        beat_in = 1; rst = 1; loop_en = 0;
        tick(); tick();
        rst = 0;
        q_notes.delete();
        start = 1; len = 4;
        tick();
        clr();
        tick(); tick();
        chk("held_no_note", q_notes.size(), 0);
        beat_in = 0; tick();
        beat_in = 1; tick();
        chk("held_then_rise", q_notes.size(), 1);
        if (q_notes.size() > 0) chk("held_lanes", q_notes[0], 1);

        // pause window drops beats
        stop = 1; tick(); clr();
        beat_in = 0; tick();
        q_notes.delete();
        start = 1; len = 4; tick(); clr();
        beat_in = 1; tick();
        beat_in = 0; tick();
        pause = 1; tick();
        chk("pause_enter", int'(paused), 1);
        for (int i = 0; i < 2; i++) begin
            beat_in = 1; tick();
            beat_in = 0; tick();
        end
        chk("pause_hold", int'(paused), 1);
        pause = 0; tick();
        chk("pause_exit", int'(paused), 0);
        chk("pause_busy", int'(busy), 1);
        beat_in = 1; tick();
        chk("pause_count", q_notes.size(), 2);
        if (q_notes.size() == 2) begin
            chk("pause_n0", q_notes[0], 1);
            chk("pause_n1", q_notes[1], 2);
        end

        // pause and rise on the same edge; stop beats start
        beat_in = 0; tick();
        begin
            int n;
            n = q_notes.size();
            beat_in = 1; pause = 1; tick();
            chk("pr_no_note", q_notes.size(), n);
            chk("pr_paused", int'(paused), 1);
        end
        pause = 0; beat_in = 0;
        stop = 1; tick(); clr();
        stop = 1; start = 1; len = 4; tick(); clr();
        chk("stop_start_busy", int'(busy), 0);

        // writes frozen during play
        start = 1; len = 4; tick(); clr();
        wr_en = 1; wr_addr = 1; wr_data = 4'hF; tick(); clr();
        q_notes.delete();
        for (int i = 0; i < 2; i++) begin
            beat_in = 1; tick();
            beat_in = 0; tick();
        end
        if (q_notes.size() == 2) chk("frozen_ram1", q_notes[1], 2);
        else chk("frozen_count", q_notes.size(), 2);
        stop = 1; tick(); clr();

        // zero length start ignored
        start = 1; len = 0; tick(); clr();
        chk("len0_busy", int'(busy), 0);

        // oversize length clips to full depth
        for (int i = 4; i < 16; i++) begin
            wr_en = 1; wr_addr = 4'(i); wr_data = 4'(i);
            tick();
        end
        clr();
        loop_en = 1; len = 20; start = 1; tick(); clr();
        q_notes.delete();
        for (int i = 0; i < 16; i++) begin
            beat_in = 1; tick();
            beat_in = 0; tick();
        end
        chk("clip_step", int'(step), 0);
        chk("clip_busy", int'(busy), 1);
        beat_in = 1; tick();
        beat_in = 0; tick();
        chk("clip_count", q_notes.size(), 17);
        if (q_notes.size() == 17) begin
            chk("clip_n15", q_notes[15], 15);
            chk("clip_n16", q_notes[16], 1);
        end
        chk("clip_step2", int'(step), 1);

        // randomized traffic against the model
        stop = 1; tick(); clr();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_addr = 4'(i);
            wr_data = 4'($urandom_range(15));
            tick();
        end
        clr();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(99) < 35) beat_in = ~beat_in;
            rst     = ($urandom_range(999) < 3);
            start   = ($urandom_range(99) < 8);
            stop    = ($urandom_range(99) < 2);
            if ($urandom_range(99) < 10) pause = ~pause;
            loop_en = ($urandom_range(99) < 60);
            len     = 5'($urandom_range(31));
            wr_en   = ($urandom_range(99) < 10);
            wr_addr = 4'($urandom_range(15));
            wr_data = 4'($urandom_range(15));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
